// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OWNER_W    = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   localparam logic [OWNER_W-1:0] OWN_NONE = 2'b00;
   localparam logic [OWNER_W-1:0] OWN_I    = 2'b01;
   localparam logic [OWNER_W-1:0] OWN_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view,
// master = the surrounding caches plus the physical memory.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic [ADDR_W-1:0] i_a;
   logic              i_access;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;

   logic [ADDR_W-1:0] d_a;
   logic [DATA_W-1:0] d_st_data;
   logic              d_access;
   logic              d_write;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_st_data;
   logic              mem_access;
   logic              mem_write;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   modport slave (
      input  i_a, i_access, d_a, d_st_data, d_access, d_write, mem_data, mem_ready,
      output i_rdata, i_ready, d_rdata, d_ready, mem_a, mem_st_data, mem_access, mem_write
   );

   modport master (
      output i_a, i_access, d_a, d_st_data, d_access, d_write, mem_data, mem_ready,
      input  i_rdata, i_ready, d_rdata, d_ready, mem_a, mem_st_data, mem_access, mem_write
   );

endinterface

// File: rtl/mem_arb_sel.sv
// Combinational winner pick between icache and dcache requests.
module mem_arb_sel (
   input  logic i_req_i,
   input  logic i_req_d,
   input  logic i_rr_mode,
   input  logic i_last_d,
   output logic o_grant_i_c,
   output logic o_grant_d_c
);

   // On a tie, dcache wins unless round-robin says it was served last.
   always_comb begin
      o_grant_i_c = 1'b0;
      o_grant_d_c = 1'b0;
      if (i_req_i && i_req_d) begin
         if (i_rr_mode && i_last_d) o_grant_i_c = 1'b1;
         else                       o_grant_d_c = 1'b1;
      end else begin
         o_grant_i_c = i_req_i;
         o_grant_d_c = i_req_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter for the single physical memory port.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed dcache priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   mem_arbiter_if.slave       bus,
   output logic [OWNER_W-1:0] owner
);

   state_t            r_state;
   state_t            w_next;
   logic              w_grant_i;
   logic              w_grant_d;
   logic              w_rr_mode;
   logic              w_last_d;
   logic [ADDR_W-1:0] w_mem_a;
   logic [DATA_W-1:0] w_mem_st_data;
   logic              w_mem_access;
   logic              w_mem_write;
   logic              w_i_ready;
   logic [DATA_W-1:0] w_i_rdata;
   logic              w_d_ready;
   logic [DATA_W-1:0] w_d_rdata;
   logic [OWNER_W-1:0] w_owner;

`ifdef MEM_ARB_RR_EN
   logic r_last_d;

   // Remember which requester won the most recent grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_d <= 1'b0;
      end else if ((r_state == IDLE) && (w_grant_i || w_grant_d)) begin
         r_last_d <= w_grant_d;
      end
   end

   assign w_rr_mode = 1'b1;
   assign w_last_d  = r_last_d;
`else
   assign w_rr_mode = 1'b0;
   assign w_last_d  = 1'b0;
`endif

   mem_arb_sel u_sel (
      .i_req_i     (bus.i_access),
      .i_req_d     (bus.d_access),
      .i_rr_mode   (w_rr_mode),
      .i_last_d    (w_last_d),
      .o_grant_i_c (w_grant_i),
      .o_grant_d_c (w_grant_d)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Grant is held for a whole transaction and released on mem_ready.
   always_comb begin
      w_next        = r_state;
      w_mem_a       = '0;
      w_mem_st_data = '0;
      w_mem_access  = 1'b0;
      w_mem_write   = 1'b0;
      w_i_ready     = 1'b0;
      w_i_rdata     = '0;
      w_d_ready     = 1'b0;
      w_d_rdata     = '0;
      w_owner       = OWN_NONE;
      case (r_state)
         IDLE: begin
            if (w_grant_d)      w_next = GRANT_D;
            else if (w_grant_i) w_next = GRANT_I;
         end
         GRANT_I: begin
            w_owner      = OWN_I;
            w_mem_a      = bus.i_a;
            w_mem_access = 1'b1;
            if (bus.mem_ready) begin
               w_i_ready = 1'b1;
               w_i_rdata = bus.mem_data;
               w_next    = IDLE;
            end
         end
         GRANT_D: begin
            w_owner       = OWN_D;
            w_mem_a       = bus.d_a;
            w_mem_st_data = bus.d_st_data;
            w_mem_write   = bus.d_write;
            w_mem_access  = 1'b1;
            if (bus.mem_ready) begin
               w_d_ready = 1'b1;
               w_d_rdata = bus.mem_data;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.mem_a       = w_mem_a;
   assign bus.mem_st_data = w_mem_st_data;
   assign bus.mem_access  = w_mem_access;
   assign bus.mem_write   = w_mem_write;
   assign bus.i_ready     = w_i_ready;
   assign bus.i_rdata     = w_i_rdata;
   assign bus.d_ready     = w_d_ready;
   assign bus.d_rdata     = w_d_rdata;
   assign owner           = w_owner;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single physical memory port between the instruction-cache and data-cache miss paths of the cached/TLB CPU. It sits between the CPU's cache refill/write-back interfaces and the physical memory block. It grants one whole transaction at a time and holds the grant until the memory's `mem_ready` pulse. It routes address, store data and the write strobe to memory, and returns read data and a ready strobe only to the granted requester.

## Interface
Parameters:
- `ADDR_W`, 32, physical address width
- `DATA_W`, 32, data word width

Ports:
- `clock`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_a`  in  ADDR_W  icache miss address; held stable while `i_access`=1
- `i_access`  in  1  icache request (read-only requester)
- `i_rdata`  out  DATA_W  read data to icache
- `i_ready`  out  1  icache transaction complete strobe
- `d_a`  in  ADDR_W  dcache address; held stable while `d_access`=1
- `d_st_data`  in  DATA_W  dcache store data
- `d_access`  in  1  dcache request
- `d_write`  in  1  dcache request is a write
- `d_rdata`  out  DATA_W  read data to dcache
- `d_ready`  out  1  dcache transaction complete strobe
- `mem_a`  out  ADDR_W  address to memory
- `mem_st_data`  out  DATA_W  store data to memory
- `mem_access`  out  1  memory request, held until `mem_ready`
- `mem_write`  out  1  memory write qualifier
- `mem_data`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory one-cycle completion pulse
- `owner`  out  2  current grant: 00 none, 01 icache, 10 dcache

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- **IDLE**:
  - Sample `i_access`/`d_access`.
  - None asserted: stay in IDLE.
  - One asserted: go to that requester's grant state.
  - Both asserted: choose a winner per Configuration.
- **GRANT_x**:
  - Drive `mem_a`, `mem_st_data` and `mem_write` from requester x's live inputs.
  - `mem_access`=1; `mem_write`=0 always in GRANT_I.
  - On `mem_ready`=1: `x_ready`=1 and `x_rdata`=`mem_data` in that same cycle; next state IDLE.
- **Outputs outside a grant**:
  - In IDLE, `mem_a`, `mem_st_data`, `mem_access` and `mem_write` are all 0.
  - The non-granted requester's `_ready` is always 0.
  - `_rdata` outputs are 0 when their `_ready` is 0.
- **Requester rule**: after seeing `x_ready`, the requester drops `x_access` or presents a new request by the next cycle. Any `x_access` high in IDLE is treated as a new request.
- **Abandoned request**: if `x_access` drops during GRANT_x before `mem_ready`, the grant is still held until `mem_ready`, and that data is discarded.
- **Spurious `mem_ready`** in IDLE is ignored: no `_ready` is asserted and the state is unchanged.
- **Reset**: state IDLE, `owner`=00, all outputs 0, RR pointer set to "icache last". Reset asserted mid-transaction forces IDLE on the next edge and `mem_access` drops. The memory is required to abandon the access.

## Timing
- Request sampled in IDLE at cycle t -> `mem_access`=1 and `owner` valid at t+1.
- `mem_ready` at cycle k -> `x_ready` at k (combinational path) -> IDLE and `mem_access`=0 at k+1.
- Earliest next grant is k+2. Back-to-back transactions are spaced by one idle turnaround cycle.
- No combinational path from `i_access`/`d_access` to `mem_access`; the grant is registered.
- `mem_ready` -> `x_ready`/`x_rdata` is the only combinational memory-to-requester path.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration; on a simultaneous request, the requester not granted last wins.
  - The 1-bit last-grant pointer updates on every grant.
  - Reset value of the pointer is icache, so dcache wins the first tie.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority, dcache always wins a tie.
  - No pointer register is generated.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, GRANT_I, GRANT_D)
  - the `owner` encodings (OWN_NONE=00, OWN_I=01, OWN_D=10)
  - default `ADDR_W`/`DATA_W` constants
- One sub-module `mem_arb_sel`: combinational winner pick from the two requests, the priority mode and the last-grant pointer.
- FSM, routing muxes and the pointer register stay in `mem_arbiter`.

## Test plan
- **Single icache read**: `i_a`=0x0000_1000, memory returns 0xDEAD_BEEF after 3 cycles.
  - `mem_access` high for 3 cycles, `mem_write`=0.
  - `i_ready`=1 with `i_rdata`=0xDEAD_BEEF; `d_ready` stays 0.
- **Single dcache write**: `d_a`=0x0000_2004, `d_st_data`=0x1234_5678, `d_write`=1.
  - `mem_a`, `mem_st_data` and `mem_write`=1 are routed while `mem_access`=1.
  - `d_ready` asserted on `mem_ready`.
- **Simultaneous requests, macro off, 4 transactions**:
  - dcache granted every tie.
  - Icache is granted only when `d_access`=0.
- **Simultaneous continuous requests, `MEM_ARB_RR_EN` on**:
  - Grant order is D, I, D, I.
  - `owner` sequence is 10, 00, 01, 00, 10, ...
- **Reset asserted mid-GRANT_D**:
  - Next cycle `mem_access`=0, `owner`=00 and all ready strobes are 0.
  - A later `mem_ready` pulse produces no `_ready`.
- **Spurious `mem_ready` in IDLE**: no `_ready`, state stays IDLE, and the next icache request is granted normally one cycle after it is sampled.
